// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg -- shared definitions for the mult_acc accumulation stage.
//
// Contents:
//   PROD_W     width of the signed product arriving from the multiplier top (32)
//   ACC_W_DEF  default accumulator / result width (40, must be >= 33)
//   LEN_W_DEF  default width of the term-count field (8)
//   state_t    controller states: IDLE, ACCUM, HOLD
package mult_acc_pkg;

  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_acc_add.sv
// mult_acc_add -- sign-extending ACC_W-bit accumulate adder.
//
// Build option: MAC_SAT_EN
//   defined   : the sum clamps to the signed ACC_W range and 'sat' flags it
//   undefined : the sum wraps modulo 2^ACC_W and the 'sat' port is absent
//
// Ports:
//   acc   in   ACC_W   signed running sum
//   prod  in   PROD_W  signed product, sign-extended to ACC_W before the add
//   sum   out  ACC_W   signed acc + prod
//   sat   out  1       the add clamped this cycle (MAC_SAT_EN only)
module mult_acc_add
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum
`ifdef MAC_SAT_EN
  ,
  output logic                     sat
`endif
);

  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef MAC_SAT_EN
  // Returns {clamped, value}. One guard bit is enough to detect overflow of a
  // two-operand add: the guard bit and the result MSB disagree exactly when
  // the true sum falls outside the ACC_W range, and the guard bit gives the sign.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0]   wide;
    logic signed [ACC_W-1:0] value;
    logic                    clamped;
    wide    = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    clamped = wide[ACC_W] ^ wide[ACC_W-1];
    if (!clamped)
      value = wide[ACC_W-1:0];
    else if (wide[ACC_W])
      value = {1'b1, {(ACC_W-1){1'b0}}};
    else
      value = {1'b0, {(ACC_W-1){1'b1}}};
    return {clamped, value};
  endfunction

  logic [ACC_W:0] add_res;

  assign add_res = sat_add(acc, prod_ext);
  assign sum     = add_res[ACC_W-1:0];
  assign sat     = add_res[ACC_W];
`else
  assign sum = acc + prod_ext;
`endif

endmodule

// File: rtl/mult_acc.sv
// mult_acc -- accumulates a programmed number of signed 32-bit products from
// the approximate Booth multiplier into an ACC_W-bit dot-product result.
//
// Build option: MAC_SAT_EN (saturating adds and sticky ovf flag; otherwise
// adds wrap and ovf is constant 0).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a run (honoured only while idle)
//   len        in   LEN_W  number of products in the run, sampled with start
//   p_valid    in   1      p_in carries a product
//   p_in       in   32     signed product
//   p_ready    out  1      product accepted this cycle when p_valid is high
//   acc_out    out  ACC_W  signed result, held until the next accepted start
//   acc_valid  out  1      acc_out holds a completed result
//   acc_ready  in   1      downstream takes the result
//   busy       out  1      a run is in progress or its result is pending
//   ovf        out  1      sticky saturation flag for the current/last run
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     p_valid,
  input  logic signed [PROD_W-1:0] p_in,
  output logic                     p_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     busy,
  output logic                     ovf
);

  state_t                  state;
  logic [LEN_W-1:0]        count;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    accept;
  logic                    run_start;

  assign p_ready   = (state == ACCUM);
  assign acc_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign accept    = p_valid && p_ready;
  assign run_start = (state == IDLE) && start;

`ifdef MAC_SAT_EN
  logic sat;

  mult_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .prod (p_in),
    .sum  (sum),
    .sat  (sat)
  );
`else
  mult_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .prod (p_in),
    .sum  (sum)
  );
`endif

  // Controller, term counter and accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            // A zero-length run goes straight to presenting a zero result.
            if (len != '0) begin
              count <= len;
              state <= ACCUM;
            end else begin
              state <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= sum;
            count <= count - LEN_W'(1);
            if (count == LEN_W'(1))
              state <= HOLD;
          end
        end
        HOLD: begin
          if (acc_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_SAT_EN
  logic ovf_q;

  // Sticky over the whole run; cleared only by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (run_start)
      ovf_q <= 1'b0;
    else if (accept && sat)
      ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_acc.sv
// tb_mult_acc -- directed and randomized bench for mult_acc at ACC_W=33,
// the narrowest legal accumulator, so overflow is easy to reach.
module tb_mult_acc;

  localparam int ACC_W = 33;
  localparam int LEN_W = 8;

  localparam longint FULL = longint'(1) <<< ACC_W;
  localparam longint HALF = FULL / 2;
  localparam longint AMAX = HALF - 1;
  localparam longint AMIN = -HALF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              p_valid;
  logic [31:0]       p_in;
  logic              p_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              busy;
  logic              ovf;

  int checks   = 0;
  int failures = 0;
  int prods[$];

  mult_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_valid   (p_valid),
    .p_in      (p_in),
    .p_ready   (p_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: ideal signed sum, then either clamped or reduced modulo 2^ACC_W.
  task automatic model_add(inout longint s, inout bit ov, input int p);
    s = s + longint'(p);
`ifdef MAC_SAT_EN
    if (s > AMAX) begin s = AMAX; ov = 1'b1; end
    else if (s < AMIN) begin s = AMIN; ov = 1'b1; end
`else
    s = s & (FULL - 1);
    if (s >= HALF) s = s - FULL;
`endif
  endtask

  // One complete run using the products in 'prods'. gap<0 -> random idle
  // cycles before each product; otherwise 'gap' idles between products.
  task automatic run(input string name, input int gap, input int hold_wait, input bit poke);
    longint           e = 0;
    bit               eo = 1'b0;
    logic [ACC_W-1:0] eb;
    int               n = prods.size();
    start = 1'b1;
    len   = n[LEN_W-1:0];
    tick();
    start = 1'b0;
    check({name, ".busy_after_start"}, 64'(busy), 64'd1);
    check({name, ".ovf_cleared"}, 64'(ovf), 64'd0);
    if (n != 0) check({name, ".p_ready_on"}, 64'(p_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
      p_valid = 1'b0;
      repeat (g) tick();
      if (g > 0) check({name, ".stall_no_valid"}, 64'(acc_valid), 64'd0);
      p_valid = 1'b1;
      p_in    = prods[i];
      tick();
      model_add(e, eo, prods[i]);
    end
    p_valid = 1'b0;
    p_in    = $urandom;
    eb      = e[ACC_W-1:0];
    check({name, ".acc_valid"}, 64'(acc_valid), 64'd1);
    check({name, ".acc_out"}, 64'(acc_out), 64'(eb));
    check({name, ".ovf"}, 64'(ovf), 64'(eo));
    check({name, ".p_ready_off"}, 64'(p_ready), 64'd0);
    acc_ready = 1'b0;
    if (poke) begin
      start = 1'b1;
      len   = 8'd3;
      tick();
      start = 1'b0;
      check({name, ".start_ignored_hold"}, 64'({acc_valid, p_ready}), 64'b10);
    end
    repeat (hold_wait) begin
      tick();
      check({name, ".held"}, 64'({acc_valid, acc_out}), 64'({1'b1, eb}));
    end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check({name, ".idle_after_hs"}, 64'({busy, acc_valid}), 64'd0);
    check({name, ".result_kept"}, 64'(acc_out), 64'(eb));
    if (poke) begin
      tick();
      check({name, ".start_not_queued"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    p_valid   = 1'b0;
    p_in      = '0;
    acc_ready = 1'b0;
    repeat (2) tick();
    check("reset.outputs", 64'({busy, acc_valid, p_ready, ovf, acc_out}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("reset.idle", 64'({busy, acc_valid, p_ready}), 64'd0);

    // Reset mid-run: two of four products taken, then asynchronous reset.
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    p_valid = 1'b1; p_in = 32'd1000; tick();
    p_in = 32'd2000; tick();
    p_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst.async", 64'({busy, acc_valid, p_ready, ovf, acc_out}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("midrst.no_result", 64'({busy, acc_valid, acc_out}), 64'd0);
    end

    // Basic back-to-back run, result taken immediately.
    prods = '{100, -50, 7};
    acc_ready = 1'b1;
    run("basic", 0, 0, 1'b0);
    check("basic.const57", 64'(acc_out), 64'd57);

    // Gapped products and 5 cycles of result backpressure.
    prods = '{32'h7FFF_FFFF, 1};
    run("gapped", 3, 5, 1'b0);
    check("gapped.const", 64'(acc_out), 64'h0_8000_0000);

    // Zero-length run with a start poked during HOLD.
    prods = {};
    run("len0", 0, 2, 1'b1);
    check("len0.const", 64'(acc_out), 64'd0);

    // Overflow at the 33-bit boundary.
    prods = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    run("ovf", 0, 1, 1'b0);
`ifdef MAC_SAT_EN
    check("ovf.const", 64'({ovf, acc_out}), 64'({1'b1, 33'h1_0000_0000}));
`else
    check("ovf.const", 64'({ovf, acc_out}), 64'({1'b0, 33'h0_8000_0000}));
`endif

    // Randomized runs with random gaps and backpressure.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      prods = {};
      for (int i = 0; i < n; i++) prods.push_back(int'($urandom));
      run("rand", -1, int'($urandom_range(0, 3)), 1'b0);
    end

    // Longest run the count field allows.
    prods = {};
    for (int i = 0; i < 255; i++) prods.push_back(int'($urandom));
    run("len255", 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_acc.md
# mult_acc

Accumulation stage that sits directly downstream of the 16x16 approximate radix-4 Booth multiplier top. Consumes the registered 32-bit signed product stream through a valid/ready handshake, sums a programmed number of consecutive products into a wide accumulator and presents the dot-product result through a second valid/ready handshake. Used to build dot-product and FIR kernels on top of the approximate multiplier.

## Interface
Parameters:
- ACC_W, 40, accumulator and result width in bits, must be >= 33
- LEN_W, 8, width of the term-count field; max terms per run is 2^LEN_W - 1

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new accumulation run; sampled only in IDLE
- len  input  LEN_W  number of products in the run, sampled with start
- p_valid  input  1  p_in carries a valid product
- p_in  input  32  signed two's-complement product from the multiplier top
- p_ready  output  1  block accepts a product this cycle
- acc_out  output  ACC_W  signed accumulated result
- acc_valid  output  1  acc_out holds a completed result
- acc_ready  input  1  downstream accepts the result
- busy  output  1  high in any state other than IDLE
- ovf  output  1  sticky saturation flag for the current/last run (MAC_SAT_EN only, else constant 0)

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: p_ready=0, acc_valid=0. start=1 with len!=0 -> load count=len, clear acc and ovf, go ACCUM. start=1 with len==0 -> clear acc and ovf, go HOLD (result 0). start=0 -> stay.
- ACCUM: p_ready=1. Product accepted when p_valid&&p_ready; acc <= acc + sign_extend(p_in) to ACC_W; count decrements. Accepting with count==1 -> go HOLD. No accept -> acc and count unchanged.
- HOLD: p_ready=0, acc_valid=1, acc_out stable. acc_valid&&acc_ready -> go IDLE. acc_out keeps last result in IDLE until the next start.
- start outside IDLE is ignored; it is not queued.
- Arithmetic: full-precision signed add at ACC_W bits; overflow behaviour per Configuration.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, count=0, acc_out=0, acc_valid=0, p_ready=0, busy=0, ovf=0. Reset mid-run discards the partial sum; no result is emitted.
- start accepted at edge t -> p_ready=1 from cycle t+1.
- Last product accepted at edge t -> acc_valid=1 and final acc_out from cycle t+1 (1-cycle latency).
- len==0: acc_valid=1 in cycle after start.
- Result handshake at edge t -> IDLE in cycle t+1; earliest new start accepted at edge t+1. Minimum run overhead: 2 cycles beyond the number of products.
- Back-to-back products: one product per cycle sustained while p_valid stays high.
- p_valid may deassert at any time in ACCUM; gaps stall the count with no loss.

## Configuration
- MAC_SAT_EN defined: each add saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1); any saturation sets ovf, which stays set until the next accepted start or reset.
- MAC_SAT_EN undefined: adds wrap modulo 2^ACC_W; ovf tied to 0; saturation logic absent.

## Structure
- Package mult_acc_pkg: state enum (IDLE, ACCUM, HOLD), default ACC_W/LEN_W constants, product width constant 32.
- Sub-module mult_acc_add: sign-extend + ACC_W-bit adder with optional saturation and overflow output, guarded by MAC_SAT_EN; top holds FSM, counter and registers.

## Test plan
- Reset mid-run: start len=4, accept 2 products, pulse rst_n low -> all outputs 0, state IDLE, no acc_valid.
- Basic run: start len=3, products 100, -50, 7 back-to-back, acc_ready=1 -> acc_valid one cycle after third accept, acc_out=57, busy low two cycles after last accept.
- Gapped/backpressure: len=2, products 0x7FFFFFFF then 1 with 3 idle cycles between, acc_ready low 5 cycles -> acc_out=0x80000000 (sign-extended positive), held stable until acc_ready.
- len=0: start with len=0 -> acc_valid next cycle with acc_out=0; start during HOLD ignored.
- Overflow, ACC_W=33: len=3, three products of -2^31 -> MAC_SAT_EN: acc_out=-2^32, ovf=1; undefined: acc_out wraps to 2^32-2^31... i.e. 0x080000000, ovf=0.
